cpu_run_ctrl: RTL and testbench
===============================

Name: cpu_run_ctrl

Overview:
- Sits directly downstream of the board clock divider. Takes its slow divided clock as a tick source and turns it into a single-cycle clock-enable pulse, cpu_ce, for the RISC-V core.
- The core therefore runs entirely on the fast board clock, with no gated or derived clock.
- Adds run/pause and single-step control from two debounced board buttons, a fast-run bypass, and a sticky halt from the core.

Parameters:
- DEBOUNCE_CYCLES, 1_000_000, consecutive clk cycles a button level must hold before it is accepted (bench uses 4).
- DB_W, 20, debounce counter width; must satisfy 2^DB_W > DEBOUNCE_CYCLES.

Ports:
- clk  input  1  board clock; all logic on its rising edge.
- rst_n  input  1  asynchronous reset, active-low, applied to every flop.
- tick_clk  input  1  divided slow clock; treated as asynchronous to clk.
- btn_run  input  1  raw button, active-high; each press toggles run/pause.
- btn_step  input  1  raw button, active-high; each press requests one step.
- mode_fast  input  1  1 = in RUN/STEP, use every clk cycle as a tick instead of tick_clk edges.
- halt_req  input  1  core halt request, level, synchronous to clk.
- cpu_ce  output  1  core clock enable, one-clk pulse per executed cycle.
- running  output  1  high while in RUN.
- halted  output  1  high while in HALT.
- ce_count  output  32  number of cpu_ce pulses since reset.

Behaviour:
- Reset (rst_n low, async): state=PAUSE; cpu_ce=0, running=0, halted=0, ce_count=0. All sync/debounce flops are cleared and no button events are pending. Reset mid-step or mid-run discards the operation.
- Tick path:
  - tick_clk passes through a 2-flop synchronizer (s0, s1) plus a delay flop sd.
  - tick_edge = s1 & ~sd.
  - Latency: tick_clk first sampled high on clk edge k gives cpu_ce high for exactly the cycle after edge k+2.
  - A high pulse of tick_clk shorter than one clk period may be missed; this is permitted.
- Fast mode: tick = mode_fast ? 1 : tick_edge. mode_fast is sampled every cycle and may change at any time.
- Debounce, per button:
  - 2-flop synchronizer, then a stable level register plus counter.
  - The counter increments while the synced level differs from the stable level, and clears when they agree.
  - When the count reaches DEBOUNCE_CYCLES-1, the stable level flips and the counter clears.
  - A rising edge of the stable level produces a one-cycle event pulse (run_ev / step_ev). Releases produce no event.
- FSM (registered state; cpu_ce registered):
  - PAUSE: run_ev goes to RUN. Otherwise step_ev goes to STEP. run_ev and step_ev in the same cycle: run wins and the step is dropped.
  - RUN: each cycle with tick=1, cpu_ce <= 1. run_ev goes to PAUSE, and no cpu_ce is issued in that cycle. step_ev is ignored.
  - STEP: waits for the first tick=1, then cpu_ce <= 1 for one cycle and returns to PAUSE. In fast mode this takes exactly one cycle after entry. run_ev/step_ev are ignored while in STEP.
  - HALT: cpu_ce=0; all button events are ignored; left only by reset.
- Priority, every state: halt_req=1 moves to HALT next cycle and suppresses cpu_ce in that cycle. This overrides tick, run_ev and step_ev.
- running = (state==RUN); halted = (state==HALT); both registered with the state.
- ce_count increments on each cycle cpu_ce=1 and wraps 0xFFFF_FFFF -> 0.
- cpu_ce is never high for two consecutive cycles except in RUN with mode_fast=1.

Test Plan:
- Reset then idle (DEBOUNCE_CYCLES=4), tick_clk toggling every 10 clk -> cpu_ce stays 0, running=0, ce_count=0.
- Press btn_run for 8 clk, tick_clk period 20 clk, run 200 clk -> running=1 from 7 clk after press; one cpu_ce per tick_clk rise, exactly 3 clk after sampling; ce_count=10 ±1.
- From PAUSE, press btn_step twice, each with 50-clk gaps -> exactly 2 cpu_ce pulses, each on the first tick edge after its event; state returns to PAUSE after each; ce_count=2.
- Set mode_fast=1 and press btn_run, then assert halt_req after 5 enables -> cpu_ce high continuously, 5 pulses, then 0. halted=1 the cycle after halt_req. Further btn_run presses are ignored; ce_count=5.
- Glitchy btn_run (high 2 clk, low 1, high 2) -> no event, state stays PAUSE. Simultaneous clean run+step presses -> RUN; no step pulse is issued.
- Preload ce_count to 0xFFFF_FFFF via force, then one cpu_ce -> ce_count=0. Assert rst_n low mid-RUN -> all outputs 0 immediately (async).

Source files
------------

// File: rtl/cpu_run_ctrl_if.sv
// Board-side control/status bundle for cpu_run_ctrl: tick source, buttons, halt and
// the clock-enable/status outputs towards the core and the board.
interface cpu_run_ctrl_if;
    logic        tick_clk;
    logic        btn_run;
    logic        btn_step;
    logic        mode_fast;
    logic        halt_req;
    logic        cpu_ce;
    logic        running;
    logic        halted;
    logic [31:0] ce_count;

    modport master (
        output tick_clk,
        output btn_run,
        output btn_step,
        output mode_fast,
        output halt_req,
        input  cpu_ce,
        input  running,
        input  halted,
        input  ce_count
    );

    modport slave (
        input  tick_clk,
        input  btn_run,
        input  btn_step,
        input  mode_fast,
        input  halt_req,
        output cpu_ce,
        output running,
        output halted,
        output ce_count
    );
endinterface

// File: rtl/cpu_run_ctrl.sv
// Run/pause/step controller: turns slow divided-clock edges into single-cycle core clock
// enables on the board clock, with debounced buttons, fast-run bypass and sticky halt.
module cpu_run_ctrl #(
    parameter int unsigned DEBOUNCE_CYCLES = 1_000_000,
    parameter int unsigned DB_W            = 20
) (
    input  logic          clk,
    input  logic          rst_n,
    cpu_run_ctrl_if.slave bus
);

    typedef enum logic [1:0] {StPause, StRun, StStep, StHalt} state_e;

    localparam logic [DB_W-1:0] DbLast = DB_W'(DEBOUNCE_CYCLES - 1);

    logic            r_tick_s0;
    logic            r_tick_s1;
    logic            r_tick_sd;
    logic            w_tick_edge;
    logic            w_tick;

    logic [1:0]      w_btn_raw;
    logic [1:0]      r_btn_s0;
    logic [1:0]      r_btn_s1;
    logic [1:0]      r_btn_lvl;
    logic [1:0]      r_btn_ev;
    logic [DB_W-1:0] r_db_cnt [2];
    logic            w_run_ev;
    logic            w_step_ev;

    state_e          r_state;
    logic            r_cpu_ce;
    logic            r_running;
    logic            r_halted;
    logic [31:0]     r_ce_count;

    // tick_clk is asynchronous to clk: two sync stages, then a delay flop for edge detect.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tick_s0 <= 1'b0;
            r_tick_s1 <= 1'b0;
            r_tick_sd <= 1'b0;
        end else begin
            r_tick_s0 <= bus.tick_clk;
            r_tick_s1 <= r_tick_s0;
            r_tick_sd <= r_tick_s1;
        end
    end

    assign w_tick_edge = r_tick_s1 & ~r_tick_sd;
    assign w_tick      = bus.mode_fast | w_tick_edge;

    // Index 0 is the run button, index 1 the step button.
    assign w_btn_raw = {bus.btn_step, bus.btn_run};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_btn_s0  <= '0;
            r_btn_s1  <= '0;
            r_btn_lvl <= '0;
            r_btn_ev  <= '0;
            for (int i = 0; i < 2; i++) begin
                r_db_cnt[i] <= '0;
            end
        end else begin
            r_btn_s0 <= w_btn_raw;
            r_btn_s1 <= r_btn_s0;
            r_btn_ev <= '0;
            for (int i = 0; i < 2; i++) begin
                if (r_btn_s1[i] == r_btn_lvl[i]) begin
                    r_db_cnt[i] <= '0;
                end else if (r_db_cnt[i] == DbLast) begin
                    r_btn_lvl[i] <= r_btn_s1[i];
                    r_db_cnt[i]  <= '0;
                    // Only an accepted press raises an event; releases are silent.
                    r_btn_ev[i]  <= r_btn_s1[i];
                end else begin
                    r_db_cnt[i] <= r_db_cnt[i] + 1'b1;
                end
            end
        end
    end

    assign w_run_ev  = r_btn_ev[0];
    assign w_step_ev = r_btn_ev[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= StPause;
            r_cpu_ce   <= 1'b0;
            r_running  <= 1'b0;
            r_halted   <= 1'b0;
            r_ce_count <= '0;
        end else begin
            if (r_cpu_ce) begin
                r_ce_count <= r_ce_count + 32'd1;
            end
            r_cpu_ce <= 1'b0;
            // Halt overrides every event and tick, from any state.
            if (bus.halt_req) begin
                r_state   <= StHalt;
                r_running <= 1'b0;
                r_halted  <= 1'b1;
            end else begin
                case (r_state)
                    StPause: begin
                        if (w_run_ev) begin
                            r_state   <= StRun;
                            r_running <= 1'b1;
                        end else if (w_step_ev) begin
                            r_state <= StStep;
                        end
                    end
                    StRun: begin
                        if (w_run_ev) begin
                            r_state   <= StPause;
                            r_running <= 1'b0;
                        end else begin
                            r_cpu_ce <= w_tick;
                        end
                    end
                    StStep: begin
                        if (w_tick) begin
                            r_cpu_ce <= 1'b1;
                            r_state  <= StPause;
                        end
                    end
                    StHalt: begin
                        r_state <= StHalt;
                    end
                    default: begin
                        r_state <= StPause;
                    end
                endcase
            end
        end
    end

    assign bus.cpu_ce   = r_cpu_ce;
    assign bus.running  = r_running;
    assign bus.halted   = r_halted;
    assign bus.ce_count = r_ce_count;

endmodule

// File: tb/tb_cpu_run_ctrl.sv
// Directed bench for cpu_run_ctrl with DEBOUNCE_CYCLES=4; inputs change 1 time unit after
// the rising edge (or on the falling edge), outputs are sampled on the falling edge.
module tb_cpu_run_ctrl;

    localparam int unsigned DbCycles = 4;
    localparam int unsigned DbW      = 3;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    cpu_run_ctrl_if bus ();

    cpu_run_ctrl #(
        .DEBOUNCE_CYCLES(DbCycles),
        .DB_W           (DbW)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int checks    = 0;
    int errors    = 0;
    int tick_half = 0;
    int last_samp = -100;

    // tick_clk generator: toggles every tick_half cycles; records the clk edge that first
    // samples each rising level.
    initial begin : tick_gen
        int cnt;
        cnt = 0;
        bus.tick_clk = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            if (tick_half == 0) begin
                bus.tick_clk = 1'b0;
                cnt = 0;
            end else begin
                cnt++;
                if (cnt >= tick_half) begin
                    cnt = 0;
                    bus.tick_clk = ~bus.tick_clk;
                    if (bus.tick_clk) last_samp = cyc + 1;
                end
            end
        end
    end

    initial begin : watchdog
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d errors=%0d",
                 checks, errors);
        $fatal(1, "time limit");
    end

    task automatic wait_cycles(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        @(posedge clk);
        #1;
        rst_n         = 1'b0;
        bus.btn_run   = 1'b0;
        bus.btn_step  = 1'b0;
        bus.mode_fast = 1'b0;
        bus.halt_req  = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
    endtask

    task automatic press(input logic run, input logic step);
        bus.btn_run  = run;
        bus.btn_step = step;
        wait_cycles(8);
        bus.btn_run  = 1'b0;
        bus.btn_step = 1'b0;
        wait_cycles(12);
    endtask

    task automatic test_reset();
        int pulses;
        int seen_run;
        pulses = 0;
        seen_run = 0;
        bus.btn_run   = 1'b0;
        bus.btn_step  = 1'b0;
        bus.mode_fast = 1'b0;
        bus.halt_req  = 1'b0;
        tick_half     = 10;
        wait_cycles(3);
        @(negedge clk);
        checks++;
        if (bus.cpu_ce !== 1'b0 || bus.running !== 1'b0 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_outputs: got ce=%b run=%b halt=%b expected 0 0 0",
                     bus.cpu_ce, bus.running, bus.halted);
        end
        checks++;
        if (bus.ce_count !== 32'd0) begin
            errors++;
            $display("FAIL reset_count: got %0d expected 0", bus.ce_count);
        end
        rst_n = 1'b1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (bus.cpu_ce === 1'b1) pulses++;
            if (bus.running === 1'b1) seen_run++;
        end
        checks++;
        if (pulses != 0) begin
            errors++;
            $display("FAIL idle_pulses: got %0d expected 0", pulses);
        end
        checks++;
        if (seen_run != 0) begin
            errors++;
            $display("FAIL idle_running: got %0d cycles expected 0", seen_run);
        end
        checks++;
        if (bus.ce_count !== 32'd0) begin
            errors++;
            $display("FAIL idle_count: got %0d expected 0", bus.ce_count);
        end
    endtask

    task automatic test_run();
        int c;
        int pulses;
        do_reset();
        tick_half = 10;
        pulses = 0;
        c = cyc;
        bus.btn_run = 1'b1;
        for (int n = 0; n < 200; n++) begin
            @(negedge clk);
            if (cyc == c + 8) bus.btn_run = 1'b0;
            if (cyc == c + 6) begin
                checks++;
                if (bus.running !== 1'b0) begin
                    errors++;
                    $display("FAIL run_early: got running=%b expected 0", bus.running);
                end
            end
            if (cyc == c + 7) begin
                checks++;
                if (bus.running !== 1'b1) begin
                    errors++;
                    $display("FAIL run_entry: got running=%b expected 1", bus.running);
                end
            end
            if (bus.cpu_ce === 1'b1) begin
                pulses++;
                checks++;
                if (cyc != last_samp + 2) begin
                    errors++;
                    $display("FAIL run_latency: got pulse at edge %0d expected edge %0d",
                             cyc, last_samp + 2);
                end
            end
        end
        checks++;
        if (pulses < 9 || pulses > 11) begin
            errors++;
            $display("FAIL run_pulses: got %0d expected 9..11", pulses);
        end
        tick_half = 0;
        for (int n = 0; n < 6; n++) begin
            @(negedge clk);
            if (bus.cpu_ce === 1'b1) pulses++;
        end
        checks++;
        if (bus.ce_count !== 32'(pulses)) begin
            errors++;
            $display("FAIL run_count: got %0d expected %0d", bus.ce_count, pulses);
        end
        wait_cycles(1);
        press(1'b1, 1'b0);
        @(negedge clk);
        checks++;
        if (bus.running !== 1'b0) begin
            errors++;
            $display("FAIL run_pause: got running=%b expected 0", bus.running);
        end
    endtask

    task automatic test_step();
        int c;
        int pulses;
        do_reset();
        tick_half = 10;
        for (int p = 0; p < 2; p++) begin
            wait_cycles(1);
            pulses = 0;
            c = cyc;
            bus.btn_step = 1'b1;
            for (int n = 0; n < 60; n++) begin
                @(negedge clk);
                if (cyc == c + 8) bus.btn_step = 1'b0;
                if (bus.cpu_ce === 1'b1) begin
                    pulses++;
                    checks++;
                    if (cyc != last_samp + 2 || cyc < c + 8 || cyc > c + 28) begin
                        errors++;
                        $display("FAIL step_edge: got pulse at %0d expected %0d within %0d..%0d",
                                 cyc, last_samp + 2, c + 8, c + 28);
                    end
                end
            end
            checks++;
            if (pulses != 1) begin
                errors++;
                $display("FAIL step_pulses: got %0d expected 1", pulses);
            end
            checks++;
            if (bus.running !== 1'b0) begin
                errors++;
                $display("FAIL step_running: got %b expected 0", bus.running);
            end
        end
        checks++;
        if (bus.ce_count !== 32'd2) begin
            errors++;
            $display("FAIL step_count: got %0d expected 2", bus.ce_count);
        end
    endtask

    task automatic test_fast_halt();
        int c;
        int pulses;
        int done;
        do_reset();
        tick_half = 0;
        bus.mode_fast = 1'b1;
        pulses = 0;
        done = 0;
        c = cyc;
        bus.btn_run = 1'b1;
        for (int n = 0; n < 100 && done == 0; n++) begin
            @(negedge clk);
            if (cyc == c + 8) bus.btn_run = 1'b0;
            if (pulses > 0) begin
                checks++;
                if (bus.cpu_ce !== 1'b1) begin
                    errors++;
                    $display("FAIL fast_continuous: got ce=%b at %0d expected 1", bus.cpu_ce, cyc);
                end
            end
            if (bus.cpu_ce === 1'b1) begin
                if (pulses == 0) begin
                    checks++;
                    if (cyc != c + 8) begin
                        errors++;
                        $display("FAIL fast_first: got edge %0d expected %0d", cyc, c + 8);
                    end
                end
                pulses++;
            end
            if (pulses == 5) begin
                bus.halt_req = 1'b1;
                done = 1;
            end
        end
        checks++;
        if (done == 0) begin
            errors++;
            $display("FAIL fast_timeout: got %0d pulses expected 5", pulses);
        end
        @(negedge clk);
        bus.halt_req = 1'b0;
        if (cyc <= c + 12) bus.btn_run = 1'b0;
        checks++;
        if (bus.cpu_ce !== 1'b0 || bus.halted !== 1'b1 || bus.running !== 1'b0) begin
            errors++;
            $display("FAIL halt_entry: got ce=%b halt=%b run=%b expected 0 1 0",
                     bus.cpu_ce, bus.halted, bus.running);
        end
        bus.btn_run = 1'b0;
        wait_cycles(10);
        pulses = 0;
        bus.btn_run = 1'b1;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (n == 8) bus.btn_run = 1'b0;
            if (bus.cpu_ce === 1'b1) pulses++;
        end
        checks++;
        if (pulses != 0 || bus.halted !== 1'b1 || bus.running !== 1'b0) begin
            errors++;
            $display("FAIL halt_sticky: got pulses=%0d halt=%b run=%b expected 0 1 0",
                     pulses, bus.halted, bus.running);
        end
        checks++;
        if (bus.ce_count !== 32'd5) begin
            errors++;
            $display("FAIL halt_count: got %0d expected 5", bus.ce_count);
        end
    endtask

    task automatic test_glitch_and_simultaneous();
        int c;
        int pulses;
        do_reset();
        tick_half = 10;
        bus.btn_run = 1'b1;
        wait_cycles(2);
        bus.btn_run = 1'b0;
        wait_cycles(1);
        bus.btn_run = 1'b1;
        wait_cycles(2);
        bus.btn_run = 1'b0;
        wait_cycles(20);
        @(negedge clk);
        checks++;
        if (bus.running !== 1'b0 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL glitch_ignored: got run=%b halt=%b expected 0 0",
                     bus.running, bus.halted);
        end
        tick_half = 0;
        wait_cycles(4);
        pulses = 0;
        c = cyc;
        bus.btn_run  = 1'b1;
        bus.btn_step = 1'b1;
        for (int n = 0; n < 40; n++) begin
            @(negedge clk);
            if (cyc == c + 8) begin
                bus.btn_run  = 1'b0;
                bus.btn_step = 1'b0;
            end
            if (bus.cpu_ce === 1'b1) pulses++;
            if (cyc == c + 7) begin
                checks++;
                if (bus.running !== 1'b1) begin
                    errors++;
                    $display("FAIL both_run_wins: got running=%b expected 1", bus.running);
                end
            end
        end
        wait_cycles(1);
        press(1'b1, 1'b0);
        bus.mode_fast = 1'b1;
        for (int n = 0; n < 10; n++) begin
            @(negedge clk);
            if (bus.cpu_ce === 1'b1) pulses++;
        end
        bus.mode_fast = 1'b0;
        checks++;
        if (pulses != 0 || bus.ce_count !== 32'd0 || bus.running !== 1'b0) begin
            errors++;
            $display("FAIL both_step_dropped: got pulses=%0d count=%0d run=%b expected 0 0 0",
                     pulses, bus.ce_count, bus.running);
        end
    endtask

    task automatic test_wrap_and_async_reset();
        int c;
        int others;
        do_reset();
        tick_half = 0;
        bus.mode_fast = 1'b1;
        force dut.r_ce_count = 32'hFFFF_FFFF;
        wait_cycles(1);
        release dut.r_ce_count;
        wait_cycles(1);
        others = 0;
        c = cyc;
        bus.btn_step = 1'b1;
        for (int n = 0; n < 20; n++) begin
            @(negedge clk);
            if (cyc == c + 8) begin
                bus.btn_step = 1'b0;
                checks++;
                if (bus.cpu_ce !== 1'b1) begin
                    errors++;
                    $display("FAIL fast_step: got ce=%b expected 1", bus.cpu_ce);
                end
            end else if (bus.cpu_ce === 1'b1) begin
                others++;
            end
        end
        checks++;
        if (others != 0 || bus.running !== 1'b0) begin
            errors++;
            $display("FAIL fast_step_once: got extra=%0d run=%b expected 0 0",
                     others, bus.running);
        end
        checks++;
        if (bus.ce_count !== 32'd0) begin
            errors++;
            $display("FAIL count_wrap: got 0x%08h expected 0x00000000", bus.ce_count);
        end
        wait_cycles(1);
        c = cyc;
        bus.btn_run = 1'b1;
        while (cyc < c + 12) @(negedge clk);
        checks++;
        if (bus.running !== 1'b1 || bus.cpu_ce !== 1'b1) begin
            errors++;
            $display("FAIL async_pre: got run=%b ce=%b expected 1 1", bus.running, bus.cpu_ce);
        end
        #2;
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.cpu_ce !== 1'b0 || bus.running !== 1'b0 || bus.halted !== 1'b0 ||
            bus.ce_count !== 32'd0) begin
            errors++;
            $display("FAIL async_reset: got ce=%b run=%b halt=%b count=%0d expected 0 0 0 0",
                     bus.cpu_ce, bus.running, bus.halted, bus.ce_count);
        end
        bus.btn_run   = 1'b0;
        bus.mode_fast = 1'b0;
        wait_cycles(2);
        rst_n = 1'b1;
        wait_cycles(2);
    endtask

    initial begin : main
        bus.btn_run   = 1'b0;
        bus.btn_step  = 1'b0;
        bus.mode_fast = 1'b0;
        bus.halt_req  = 1'b0;
        test_reset();
        test_run();
        test_step();
        test_fast_halt();
        test_glitch_and_simultaneous();
        test_wrap_and_async_reset();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
